// File: rtl/i2s_stream_checker.sv
// i2s_stream_checker
//   AXI-Stream sink for the multi-channel I2S receiver output. It locks onto
//   the sender's incrementing test pattern and then checks every beat for the
//   sample value, the channel/side order and the TLAST framing. It also drives
//   a rotating TREADY stall mask so the upstream FIFOs see back-pressure.
//
// Ports
//   s00_axis_aclk / s00_axis_aresetn : clock, synchronous active-low reset
//   s00_axis_t*                      : stream input; tdata = {side, ch[6:0], sample[23:0]}
//   s00_axis_tready                  : registered back-pressure
//   enable, stall_pattern            : run control and the 8-bit TREADY mask
//   clear_counters                   : one-cycle pulse that zeroes the counters
//   locked                           : high while in CHECK
//   beat_cnt .. resync_cnt           : saturating counters
//   first_err_slot / first_err_data  : slot and sample of the first data error
module i2s_stream_checker #(
    parameter int I2S_RECEIVER_NUM       = 16,
    parameter int C_S00_AXIS_TDATA_WIDTH = 32,
    parameter int I2S_DATA_BIT_WIDTH     = 24,
    parameter int ERR_CNT_WIDTH          = 32
) (
    input  logic                                s00_axis_aclk,
    input  logic                                s00_axis_aresetn,
    input  logic                                s00_axis_tvalid,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
    input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb,
    input  logic                                s00_axis_tlast,
    output logic                                s00_axis_tready,
    input  logic                                enable,
    input  logic [7:0]                          stall_pattern,
    input  logic                                clear_counters,
    output logic                                locked,
    output logic [ERR_CNT_WIDTH-1:0]            beat_cnt,
    output logic [ERR_CNT_WIDTH-1:0]            frame_cnt,
    output logic [ERR_CNT_WIDTH-1:0]            data_err_cnt,
    output logic [ERR_CNT_WIDTH-1:0]            order_err_cnt,
    output logic [ERR_CNT_WIDTH-1:0]            last_err_cnt,
    output logic [ERR_CNT_WIDTH-1:0]            resync_cnt,
    output logic [7:0]                          first_err_slot,
    output logic [I2S_DATA_BIT_WIDTH-1:0]       first_err_data
);

    localparam int NSLOT = 2 * I2S_RECEIVER_NUM;
    localparam int SW    = $clog2(NSLOT);
    localparam int DW    = I2S_DATA_BIT_WIDTH;
    localparam int CW    = ERR_CNT_WIDTH;

    typedef enum logic [1:0] {IDLE, SYNC, SEED, CHECK} state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   slot_q, slot_d;
    logic [2:0]      rot_q;
    logic            err_armed_q;
    logic [DW-1:0]   exp_ram [NSLOT];

    // Byte strobes carry no information for this sink.
    logic unused_tstrb;
    assign unused_tstrb = ^s00_axis_tstrb;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + CW'(1);
    endfunction

    // Beat fields
    logic [DW-1:0] sample;
    logic          side_in;
    logic [6:0]    ch_in;
    assign sample  = s00_axis_tdata[DW-1:0];
    assign side_in = s00_axis_tdata[31];
    assign ch_in   = s00_axis_tdata[30:24];

    // Slot decode: first half of the frame is the L side, second half R.
    logic [7:0] slot_x;
    logic       exp_side;
    logic [6:0] exp_ch;
    logic       last_slot;
    assign slot_x    = 8'(slot_q);
    assign exp_side  = (slot_x >= 8'(I2S_RECEIVER_NUM));
    assign exp_ch    = exp_side ? 7'(slot_x - 8'(I2S_RECEIVER_NUM)) : 7'(slot_x);
    assign last_slot = (slot_q == SW'(NSLOT - 1));

    // Beat events. A beat that arrives while enable is already low is
    // dropped so the counters hold from the moment enable falls.
    logic acc, active, ord_err, last_err, resync_ev, data_err, frame_done, ram_we;
    assign acc        = s00_axis_tvalid & s00_axis_tready & enable;
    assign active     = (state_q == SEED) || (state_q == CHECK);
    assign ord_err    = acc & active & ({side_in, ch_in} != {exp_side, exp_ch});
    assign last_err   = acc & active & (s00_axis_tlast != last_slot);
    assign resync_ev  = ord_err | last_err;
    // A misordered beat belongs to another slot, so its sample is not judged.
    assign data_err   = acc & (state_q == CHECK) & ~ord_err & (sample != exp_ram[slot_q]);
    assign frame_done = acc & (state_q == CHECK) & last_slot & s00_axis_tlast & ~ord_err;
    assign ram_we     = acc & active & s00_axis_aresetn;

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        case (state_q)
            IDLE:    state_d = SYNC;
            SYNC:    if (acc && s00_axis_tlast) state_d = SEED;
            SEED:    if (resync_ev) state_d = SYNC;
                     else if (acc && last_slot) state_d = CHECK;
            CHECK:   if (resync_ev) state_d = SYNC;
            default: state_d = IDLE;
        endcase
        if (active && acc)
            slot_d = (resync_ev || last_slot) ? '0 : slot_q + SW'(1);
        if (!active)
            slot_d = '0;
        if (!enable) begin
            state_d = IDLE;
            slot_d  = '0;
        end
    end

    always_ff @(posedge s00_axis_aclk) begin
        if (!s00_axis_aresetn) begin
            state_q         <= IDLE;
            slot_q          <= '0;
            rot_q           <= '0;
            s00_axis_tready <= 1'b0;
            locked          <= 1'b0;
        end else begin
            state_q         <= state_d;
            slot_q          <= slot_d;
            rot_q           <= rot_q + 3'd1;
            s00_axis_tready <= enable & stall_pattern[rot_q] & (state_q != IDLE);
            locked          <= (state_d == CHECK);
        end
    end

    // The next expected value for each slot is always the last seen sample
    // plus one; the 24-bit wrap falls out of the modular add.
    always_ff @(posedge s00_axis_aclk) begin
        if (ram_we)
            exp_ram[slot_q] <= sample + DW'(1);
    end

    always_ff @(posedge s00_axis_aclk) begin
        if (!s00_axis_aresetn || clear_counters) begin
            beat_cnt       <= '0;
            frame_cnt      <= '0;
            data_err_cnt   <= '0;
            order_err_cnt  <= '0;
            last_err_cnt   <= '0;
            resync_cnt     <= '0;
            first_err_slot <= '0;
            first_err_data <= '0;
            err_armed_q    <= 1'b1;
        end else begin
            if (acc && state_q != IDLE) beat_cnt <= sat_inc(beat_cnt);
            if (frame_done)             frame_cnt <= sat_inc(frame_cnt);
            if (ord_err)                order_err_cnt <= sat_inc(order_err_cnt);
            if (last_err)               last_err_cnt <= sat_inc(last_err_cnt);
            if (resync_ev)              resync_cnt <= sat_inc(resync_cnt);
            if (data_err) begin
                data_err_cnt <= sat_inc(data_err_cnt);
                if (err_armed_q) begin
                    first_err_slot <= slot_x;
                    first_err_data <= sample;
                    err_armed_q    <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_stream_checker.sv
// Bench for i2s_stream_checker: a pattern sender feeds frames, a table of
// scenarios drives faults, and expected counter snapshots are queued and
// compared once each scenario has drained.
module tb_i2s_stream_checker;

    localparam int N  = 16;
    localparam int NS = 2 * N;

    logic        clk = 1'b0;
    logic        rstn;
    logic        tvalid, tlast, tready, enable, clear, locked;
    logic [31:0] tdata;
    logic [3:0]  tstrb;
    logic [7:0]  stall;
    logic [31:0] beat_cnt, frame_cnt, data_err_cnt, order_err_cnt, last_err_cnt, resync_cnt;
    logic [7:0]  first_err_slot;
    logic [23:0] first_err_data;

    always #5 clk = ~clk;

    i2s_stream_checker #(
        .I2S_RECEIVER_NUM(N), .C_S00_AXIS_TDATA_WIDTH(32),
        .I2S_DATA_BIT_WIDTH(24), .ERR_CNT_WIDTH(32)
    ) dut (
        .s00_axis_aclk(clk), .s00_axis_aresetn(rstn),
        .s00_axis_tvalid(tvalid), .s00_axis_tdata(tdata), .s00_axis_tstrb(tstrb),
        .s00_axis_tlast(tlast), .s00_axis_tready(tready),
        .enable(enable), .stall_pattern(stall), .clear_counters(clear),
        .locked(locked), .beat_cnt(beat_cnt), .frame_cnt(frame_cnt),
        .data_err_cnt(data_err_cnt), .order_err_cnt(order_err_cnt),
        .last_err_cnt(last_err_cnt), .resync_cnt(resync_cnt),
        .first_err_slot(first_err_slot), .first_err_data(first_err_data)
    );

    typedef struct {
        string      name;
        logic [7:0] stall;
        bit         resync;  // drop/raise enable, then a sync frame and a seed frame
        bit         set_p0;  // preload ch0 L so the seed value is FFFFFE
        int         fault;   // 0 none, 1 slot19 +2, 2 swap ch5/ch6 L, 3 drop tlast
        int         nfr;     // clean frames after the fault frame
        int beat; int frame; int derr; int oerr; int lerr; int rsy; int drops;
    } vec_t;

    typedef struct {
        int beat; int frame; int derr; int oerr; int lerr; int rsy; int drops; int fslot;
        logic [23:0] fdata;
    } exp_t;

    vec_t        tbl [6];
    exp_t        sb_q [$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [23:0] pat [NS];
    int          lock_drops = 0;
    logic        locked_prev = 1'b0;

    always @(negedge clk) begin
        if (locked_prev && !locked) lock_drops++;
        locked_prev = locked;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        cycles(1);
        clear = 1'b0;
    endtask

    function automatic logic [31:0] mk_word(input int s, input logic [23:0] v);
        logic       side;
        logic [6:0] ch;
        side = (s >= N);
        ch   = 7'(s % N);
        return {side, ch, v};
    endfunction

    task automatic send_beat(input logic [31:0] w, input logic l);
        int   waited;
        logic t;
        waited = 0;
        tdata  = w;
        tlast  = l;
        tvalid = 1'b1;
        forever begin
            @(negedge clk);
            t = tready;
            @(posedge clk);
            #1;
            if (t) break;
            waited++;
            if (waited > 200) begin
                n_vec++;
                n_err++;
                $display("FAIL accept_timeout: tready low for %0d cycles, expected a handshake", waited);
                break;
            end
        end
        tvalid = 1'b0;
    endtask

    task automatic send_frame(input int fault, input int nb);
        for (int i = 0; i < nb; i++) begin
            int          j;
            logic [23:0] v;
            j = i;
            if (fault == 2 && i == 5) j = 6;
            else if (fault == 2 && i == 6) j = 5;
            v = pat[j];
            if (fault == 1 && j == 19) v = v + 24'd2;
            send_beat(mk_word(j, v), (i == NS - 1) && (fault != 3));
        end
        if (nb == NS)
            for (int s = 0; s < NS; s++) pat[s] = pat[s] + 24'd1;
    endtask

    initial begin
        exp_t e;
        int   base, cnt;
        rstn = 1'b0; enable = 1'b0; stall = 8'hFF; clear = 1'b0;
        tvalid = 1'b0; tdata = '0; tstrb = '0; tlast = 1'b0;
        for (int s = 0; s < NS; s++) pat[s] = 24'(s * 'h010101);

        //          name        stall  rs  p0 flt nfr  beat  frm de oe le rs drop
        tbl[0] = '{"lock_100",  8'hFF, 1, 0, 0, 100, 3264, 100, 0, 0, 0, 0, 0};
        tbl[1] = '{"stall_a5",  8'hA5, 0, 0, 0, 100, 3200, 100, 0, 0, 0, 0, 0};
        tbl[2] = '{"data_inj",  8'hFF, 0, 0, 1,   2,   96,   3, 2, 0, 0, 0, 0};
        tbl[3] = '{"wrap",      8'hFF, 1, 1, 0,   3,  160,   3, 0, 0, 0, 0, 1};
        tbl[4] = '{"swap_5_6",  8'hFF, 0, 0, 2,   2,   96,   1, 0, 1, 0, 1, 1};
        tbl[5] = '{"drop_last", 8'hFF, 0, 0, 3,   3,  128,   1, 0, 0, 1, 1, 1};

        cycles(3);
        chk("rst.tready", 32'(tready), 0);
        chk("rst.locked", 32'(locked), 0);
        chk("rst.beat_cnt", beat_cnt, 0);
        chk("rst.frame_cnt", frame_cnt, 0);
        chk("rst.data_err_cnt", data_err_cnt, 0);
        chk("rst.order_err_cnt", order_err_cnt, 0);
        chk("rst.last_err_cnt", last_err_cnt, 0);
        chk("rst.resync_cnt", resync_cnt, 0);
        chk("rst.first_err_slot", 32'(first_err_slot), 0);
        chk("rst.first_err_data", 32'(first_err_data), 0);
        rstn = 1'b1;
        cycles(2);

        for (int v = 0; v < 6; v++) begin
            stall = tbl[v].stall;
            pulse_clear();
            e.beat  = tbl[v].beat;  e.frame = tbl[v].frame; e.derr = tbl[v].derr;
            e.oerr  = tbl[v].oerr;  e.lerr  = tbl[v].lerr;  e.rsy  = tbl[v].rsy;
            e.drops = tbl[v].drops;
            e.fslot = (tbl[v].fault == 1) ? 19 : 0;
            e.fdata = (tbl[v].fault == 1) ? pat[19] + (tbl[v].resync ? 24'd2 : 24'd0) + 24'd2 : 24'd0;
            sb_q.push_back(e);
            base = lock_drops;
            if (tbl[v].resync) begin
                enable = 1'b0;
                cycles(3);
                if (tbl[v].set_p0) pat[0] = 24'hFFFFFD;
                enable = 1'b1;
                send_frame(0, NS);
                send_frame(0, NS);
            end
            if (tbl[v].fault != 0) send_frame(tbl[v].fault, NS);
            repeat (tbl[v].nfr) send_frame(0, NS);
            cycles(4);
            e = sb_q.pop_front();
            chk({tbl[v].name, ".beat_cnt"}, beat_cnt, e.beat);
            chk({tbl[v].name, ".frame_cnt"}, frame_cnt, e.frame);
            chk({tbl[v].name, ".data_err_cnt"}, data_err_cnt, e.derr);
            chk({tbl[v].name, ".order_err_cnt"}, order_err_cnt, e.oerr);
            chk({tbl[v].name, ".last_err_cnt"}, last_err_cnt, e.lerr);
            chk({tbl[v].name, ".resync_cnt"}, resync_cnt, e.rsy);
            chk({tbl[v].name, ".lock_drops"}, lock_drops - base, e.drops);
            chk({tbl[v].name, ".locked"}, 32'(locked), 1);
            chk({tbl[v].name, ".first_err_slot"}, 32'(first_err_slot), e.fslot);
            chk({tbl[v].name, ".first_err_data"}, 32'(first_err_data), 32'(e.fdata));
        end

        // TREADY duty with the 1010_0101 mask: 8 of any 16 cycles.
        stall = 8'hA5;
        cnt   = 0;
        repeat (16) begin
            @(negedge clk);
            if (tready) cnt++;
        end
        cycles(1);
        chk("duty_a5.tready_high", cnt, 8);

        // Partial frame, then enable low: counters hold, clear zeroes them.
        send_frame(0, 10);
        enable = 1'b0;
        cycles(2);
        chk("disable.beat_cnt_hold", beat_cnt, 138);
        chk("disable.locked", 32'(locked), 0);
        chk("disable.tready", 32'(tready), 0);
        pulse_clear();
        cycles(1);
        chk("clear.beat_cnt", beat_cnt, 0);
        chk("clear.frame_cnt", frame_cnt, 0);
        chk("clear.last_err_cnt", last_err_cnt, 0);
        chk("clear.resync_cnt", resync_cnt, 0);
        chk("clear.tready", 32'(tready), 0);

        // Reset in the middle of a frame while syncing.
        enable = 1'b1;
        send_frame(0, 10);
        cycles(1);
        chk("sync.beat_cnt", beat_cnt, 10);
        rstn = 1'b0;
        cycles(1);
        chk("midrst.beat_cnt", beat_cnt, 0);
        chk("midrst.tready", 32'(tready), 0);
        chk("midrst.locked", 32'(locked), 0);
        rstn = 1'b1;
        cycles(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
